// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo datapath constants: reservation-station tags, CDB idle sentinel and helpers.
// Used by cdb_arbiter, register_status and the reservation stations.
package tomasulo_pkg;

    localparam logic [2:0]  FREE_REGISTER    = 3'd0;
    localparam logic [2:0]  RES_STATION_ADD1 = 3'd1;
    localparam logic [2:0]  RES_STATION_ADD2 = 3'd2;
    localparam logic [2:0]  Qj_Qk_sem_valor  = 3'd0;
    localparam logic [15:0] NO_DATA          = 16'b1111_1111_1111_0000;

    // Reduces idx into [0, n) for idx < 2n, i.e. a single wrap of a ring index.
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
// Produces a one-hot grant, the winner index and an any-grant flag.
module rr_priority_picker
    import tomasulo_pkg::*;
#(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] win_idx,
    output logic             any
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        grant   = '0;
        win_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = PTR_W'(rr_wrap(32'(ptr) + k, N_REQ));
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                win_idx     = cand;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant, registered tag/result broadcast.
// Define CDB_ARB_FIXED_PRIORITY_EN for lowest-index-wins priority with no pointer register.
module cdb_arbiter #(
    parameter int unsigned        N_REQ   = 3,
    parameter int unsigned        TAG_W   = 3,
    parameter int unsigned        DATA_W  = 16,
    parameter logic [DATA_W-1:0]  NO_DATA = DATA_W'(tomasulo_pkg::NO_DATA),
    localparam int unsigned       PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [N_REQ-1:0]        Req_valid,
    input  logic [N_REQ*DATA_W-1:0] Req_data,
    output logic [N_REQ-1:0]        Req_ready,
    output logic [TAG_W-1:0]        Qi_CDB,
    output logic [DATA_W-1:0]       Qi_CDB_data,
    output logic [PTR_W-1:0]        Grant_ptr
);

    import tomasulo_pkg::*;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] win_idx;
    logic [N_REQ-1:0] grant;
    logic             any;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req     (Req_valid),
        .ptr     (ptr_q),
        .grant   (grant),
        .win_idx (win_idx),
        .any     (any)
    );

    // Grant implies valid, so any grant is a transfer this cycle.
    assign Req_ready = grant;
    assign Grant_ptr = ptr_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Qi_CDB      <= TAG_W'(FREE_REGISTER);
            Qi_CDB_data <= NO_DATA;
        end else if (any) begin
            Qi_CDB      <= TAG_W'(win_idx) + TAG_W'(1);
            Qi_CDB_data <= Req_data[win_idx*DATA_W +: DATA_W];
        end else begin
            Qi_CDB      <= TAG_W'(FREE_REGISTER);
            Qi_CDB_data <= NO_DATA;
        end
    end

`ifdef CDB_ARB_FIXED_PRIORITY_EN
    assign ptr_q = '0;
`else
    logic [PTR_W-1:0] ptr_d;

    // Last winner drops to lowest priority.
    always_comb begin
        ptr_d = ptr_q;
        if (any) begin
            ptr_d = PTR_W'(rr_wrap(32'(win_idx) + 32'd1, N_REQ));
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: reference model predicts grants and CDB broadcasts,
// a separate monitor compares the registered outputs each cycle.
module tb_cdb_arbiter;

    localparam int N  = 3;
    localparam int TW = 3;
    localparam int DW = 16;
    localparam logic [DW-1:0] IDLE = 16'hFFF0;

    logic            Clock = 1'b0;
    logic            Reset = 1'b1;
    logic [N-1:0]    Req_valid;
    logic [N*DW-1:0] Req_data;
    logic [N-1:0]    Req_ready;
    logic [TW-1:0]   Qi_CDB;
    logic [DW-1:0]   Qi_CDB_data;
    logic [1:0]      Grant_ptr;

    cdb_arbiter dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Req_valid   (Req_valid),
        .Req_data    (Req_data),
        .Req_ready   (Req_ready),
        .Qi_CDB      (Qi_CDB),
        .Qi_CDB_data (Qi_CDB_data),
        .Grant_ptr   (Grant_ptr)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic [1:0]    ptr;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            compared   = 0;
    int            mismatched = 0;
    bit            v_m[N];
    logic [DW-1:0] d_m[N];
    int            ptr_m = 0;
    int            won = -1;
    int            wait_c[N];
    bit [N-1:0]    reassert = '0;
    bit            rnd = 1'b0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            Req_valid[i]         = v_m[i];
            Req_data[i*DW +: DW] = d_m[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    // One bus cycle: predict at the falling edge, update requesters just after the rising edge.
    task automatic step(input bit rst_here);
        int         w;
        int         start;
        logic [N-1:0] exp_rdy;
        exp_t       e;
        @(negedge Clock);
`ifdef CDB_ARB_FIXED_PRIORITY_EN
        start = 0;
`else
        start = ptr_m;
`endif
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && v_m[(start + k) % N]) w = (start + k) % N;
        end
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", 32'(Req_ready), 32'(exp_rdy));
        for (int i = 0; i < N; i++) if (v_m[i] && i != w) wait_c[i]++;
        if (w >= 0) begin
`ifndef CDB_ARB_FIXED_PRIORITY_EN
            compared++;
            if (wait_c[w] >= N) begin
                mismatched++;
                $display("FAIL fairness: requester %0d waited %0d cycles, limit %0d",
                         w, wait_c[w], N - 1);
            end
            ptr_m = (w + 1) % N;
`endif
            wait_c[w] = 0;
            e.tag  = TW'(w + 1);
            e.data = d_m[w];
        end else begin
            e.tag  = '0;
            e.data = IDLE;
        end
        e.ptr = 2'(ptr_m);
        sb.push_back(e);
        won = w;
        if (rst_here) begin
            #2 Reset = 1'b1;
            sb.delete();
            won   = -1;
            ptr_m = 0;
            for (int i = 0; i < N; i++) wait_c[i] = 0;
            #1;
            chk("async_rst_tag",  32'(Qi_CDB),      32'd0);
            chk("async_rst_data", 32'(Qi_CDB_data), 32'(IDLE));
            chk("async_rst_ptr",  32'(Grant_ptr),   32'd0);
            @(posedge Clock);
            #1 Reset = 1'b0;
        end else begin
            @(posedge Clock);
            #1;
        end
        if (won >= 0) begin
            if (reassert[won] || (rnd && $urandom_range(0, 1) == 1)) d_m[won] = DW'($urandom);
            else v_m[won] = 1'b0;
        end
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                if (!v_m[i] && $urandom_range(0, 2) == 0) begin
                    v_m[i] = 1'b1;
                    d_m[i] = DW'($urandom);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge Clock);
            #2;
            if (!Reset && sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("cdb_tag",  32'(Qi_CDB),      32'(mon_e.tag));
                chk("cdb_data", 32'(Qi_CDB_data), 32'(mon_e.data));
                chk("grant_ptr", 32'(Grant_ptr),  32'(mon_e.ptr));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            v_m[i]    = 1'b0;
            d_m[i]    = '0;
            wait_c[i] = 0;
        end
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_tag",  32'(Qi_CDB),      32'd0);
        chk("reset_data", 32'(Qi_CDB_data), 32'(IDLE));
        chk("reset_ptr",  32'(Grant_ptr),   32'd0);
        Reset = 1'b0;

        // All three valid from pointer 0, each held until granted.
        for (int i = 0; i < N; i++) begin
            v_m[i] = 1'b1;
            d_m[i] = DW'(16'h1111 * (i + 1));
        end
        repeat (4) step(1'b0);

        // Single requester.
        v_m[1] = 1'b1;
        d_m[1] = 16'h0042;
        repeat (3) step(1'b0);

        // Reset lands in the cycle requester 1 holds the grant.
        for (int i = 0; i < N; i++) begin
            v_m[i] = 1'b1;
            d_m[i] = DW'(16'hA000 + i);
        end
        step(1'b0);
        step(1'b0);
        step(1'b1);
        repeat (4) step(1'b0);

        // Requester 0 re-asserts after every grant while requester 2 waits.
        reassert = 3'b001;
        v_m[0] = 1'b1; d_m[0] = 16'h0C00;
        v_m[2] = 1'b1; d_m[2] = 16'h0C02;
        repeat (10) step(1'b0);
        reassert = '0;

        // Randomised traffic with occasional mid-burst resets.
        rnd = 1'b1;
        repeat (400) step($urandom_range(0, 59) == 0);
        rnd = 1'b0;
        repeat (N + 3) step(1'b0);

        #5;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
